// File: rtl/gin_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : gin_scheduler_if
//  Description : Packet handshake and GIN bus signal bundle for the GIN
//                multicast scheduler.
//                master : scheduler side (accepts packets, drives the bus)
//                slave  : packet source plus bus side (offers packets,
//                         returns controller readiness)
//  Signals     : pkt_valid/pkt_tag/pkt_data/pkt_ready - upstream packet
//                handshake; bus_program/bus_scan_tag - scan chain
//                programming; bus_enable/bus_tag/bus_data - packet issue;
//                bus_ready - per-controller ready vector.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gin_scheduler_if #(
    parameter int BITWIDTH        = 16,
    parameter int TAG_LENGTH      = 4,
    parameter int NUM_CONTROLLERS = 10
);
    logic                       pkt_valid;
    logic [TAG_LENGTH-1:0]      pkt_tag;
    logic [BITWIDTH-1:0]        pkt_data;
    logic                       pkt_ready;
    logic                       bus_program;
    logic [TAG_LENGTH-1:0]      bus_scan_tag;
    logic                       bus_enable;
    logic [TAG_LENGTH-1:0]      bus_tag;
    logic [BITWIDTH-1:0]        bus_data;
    logic [NUM_CONTROLLERS-1:0] bus_ready;

    modport master (
        input  pkt_valid, pkt_tag, pkt_data, bus_ready,
        output pkt_ready, bus_program, bus_scan_tag, bus_enable, bus_tag, bus_data
    );

    modport slave (
        output pkt_valid, pkt_tag, pkt_data, bus_ready,
        input  pkt_ready, bus_program, bus_scan_tag, bus_enable, bus_tag, bus_data
    );
endinterface
`default_nettype wire

// File: rtl/gin_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : gin_scheduler
//  Description : Sequencing controller for the GIN multicast bus. Programs
//                the controller tag scan chain from a parallel tag table,
//                then issues (tag, data) packets as one-cycle bus enables
//                whenever every multicast controller reports ready.
//  Ports       : clk          - clock, rising edge
//                rstb         - synchronous active-high reset
//                cfg_start    - one-cycle request to (re)program the chain
//                cfg_tags     - tag table, slice i is controller i's tag
//                cfg_done     - high while the chain is programmed (RUN)
//                stall_cycles - saturating stall counter
//                gin          - packet handshake and bus signals (master)
//  Options     : GIN_STALL_CNT_EN - builds the stall counter; otherwise
//                stall_cycles is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module gin_scheduler #(
    parameter int BITWIDTH        = 16,
    parameter int TAG_LENGTH      = 4,
    parameter int NUM_CONTROLLERS = 10
) (
    input  wire logic                                  clk,
    input  wire logic                                  rstb,
    input  wire logic                                  cfg_start,
    input  wire logic [TAG_LENGTH*NUM_CONTROLLERS-1:0] cfg_tags,
    output logic                                       cfg_done,
    output logic [15:0]                                stall_cycles,
    gin_scheduler_if.master                            gin
);

    localparam int c_CNT_W = $clog2(NUM_CONTROLLERS) + 1;
    localparam int c_TBL_W = TAG_LENGTH * NUM_CONTROLLERS;
    localparam logic [c_CNT_W-1:0] c_LAST_K = c_CNT_W'(NUM_CONTROLLERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROGRAM = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [c_CNT_W-1:0]     k_q, k_d;
    // Latched tag table, kept as a shift register: the top slice is always
    // the next tag to shift, so slice (N-1-k) is emitted on PROGRAM cycle k.
    logic [c_TBL_W-1:0]     tags_q, tags_d;
    logic                   program_q, program_d;
    logic [TAG_LENGTH-1:0]  scan_tag_q, scan_tag_d;
    logic                   enable_q, enable_d;
    logic [TAG_LENGTH-1:0]  tag_q, tag_d;
    logic [BITWIDTH-1:0]    data_q, data_d;
    logic                   done_q, done_d;

    logic w_pkt_ready;
    logic w_pkt_accept;
    logic w_cfg_accept;

    // The ~enable term leaves a gap cycle after every issue so controllers
    // have time to drop ready before the next packet is considered.
    assign w_pkt_ready  = (state_q == ST_RUN) & (&gin.bus_ready) & ~enable_q & ~cfg_start;
    assign w_pkt_accept = gin.pkt_valid & w_pkt_ready;
    assign w_cfg_accept = cfg_start & ((state_q == ST_IDLE) |
                                       ((state_q == ST_RUN) & ~enable_q));

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        tags_d     = tags_q;
        program_d  = 1'b0;
        scan_tag_d = scan_tag_q;
        enable_d   = 1'b0;
        tag_d      = tag_q;
        data_d     = data_q;
        done_d     = done_q;

        case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
            end
            ST_PROGRAM: begin
                if (k_q == c_LAST_K) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    k_d        = k_q + c_CNT_W'(1);
                    program_d  = 1'b1;
                    scan_tag_d = tags_q[c_TBL_W-1 -: TAG_LENGTH];
                    tags_d     = tags_q << TAG_LENGTH;
                end
            end
            ST_RUN: begin
                if (w_pkt_accept) begin
                    enable_d = 1'b1;
                    tag_d    = gin.pkt_tag;
                    data_d   = gin.pkt_data;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Start programming straight from the incoming table so the first
        // (farthest) tag is already on the bus in PROGRAM cycle 0.
        if (w_cfg_accept) begin
            state_d    = ST_PROGRAM;
            k_d        = '0;
            program_d  = 1'b1;
            scan_tag_d = cfg_tags[c_TBL_W-1 -: TAG_LENGTH];
            tags_d     = cfg_tags << TAG_LENGTH;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            tags_q     <= '0;
            program_q  <= 1'b0;
            scan_tag_q <= '0;
            enable_q   <= 1'b0;
            tag_q      <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            tags_q     <= tags_d;
            program_q  <= program_d;
            scan_tag_q <= scan_tag_d;
            enable_q   <= enable_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            done_q     <= done_d;
        end
    end

`ifdef GIN_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (w_cfg_accept) begin
            stall_d = '0;
        end else if ((state_q == ST_RUN) && gin.pkt_valid && !w_pkt_ready &&
                     (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    assign cfg_done         = done_q;
    assign gin.pkt_ready    = w_pkt_ready;
    assign gin.bus_program  = program_q;
    assign gin.bus_scan_tag = scan_tag_q;
    assign gin.bus_enable   = enable_q;
    assign gin.bus_tag      = tag_q;
    assign gin.bus_data     = data_q;

endmodule
`default_nettype wire

// File: tb/tb_gin_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gin_scheduler
//  Description : Self-checking bench for gin_scheduler: scan chain
//                programming, packet issue pacing, ready stalls, cfg_start
//                priority, mid-program reset, randomized traffic against a
//                scoreboard model, and stall counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gin_scheduler;

    localparam int BW = 16;
    localparam int TL = 4;
    localparam int N  = 10;

    logic              clk = 1'b0;
    logic              rstb;
    logic              cfg_start;
    logic [TL*N-1:0]   cfg_tags;
    logic              cfg_done;
    logic [15:0]       stall_cycles;

    int checks = 0;
    int errors = 0;

    gin_scheduler_if #(.BITWIDTH(BW), .TAG_LENGTH(TL), .NUM_CONTROLLERS(N)) gin_if ();

    gin_scheduler #(.BITWIDTH(BW), .TAG_LENGTH(TL), .NUM_CONTROLLERS(N)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .cfg_start    (cfg_start),
        .cfg_tags     (cfg_tags),
        .cfg_done     (cfg_done),
        .stall_cycles (stall_cycles),
        .gin          (gin_if)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Requests programming with the given table and walks the PROGRAM phase,
    // expecting controller (N-1-k)'s tag on cycle k, then RUN with cfg_done.
    task automatic do_program(input logic [TL*N-1:0] tbl);
        logic [TL-1:0] exp_tag;
        cfg_tags  = tbl;
        cfg_start = 1'b1;
        #1;
        checks++;
        if (gin_if.pkt_ready !== 1'b0) begin
            errors++;
            $display("FAIL prog_pkt_ready: got %b want 0", gin_if.pkt_ready);
        end
        cyc();
        cfg_start       = 1'b0;
        gin_if.pkt_valid = 1'b0;
        checks++;
        if (cfg_done !== 1'b0 || gin_if.bus_enable !== 1'b0) begin
            errors++;
            $display("FAIL prog_entry: cfg_done=%b bus_enable=%b want 0/0", cfg_done, gin_if.bus_enable);
        end
        for (int k = 0; k < N; k++) begin
            exp_tag = tbl[TL*(N-1-k) +: TL];
            checks++;
            if (gin_if.bus_program !== 1'b1 || gin_if.bus_scan_tag !== exp_tag || cfg_done !== 1'b0) begin
                errors++;
                $display("FAIL prog_shift[%0d]: program=%b scan=%h done=%b want 1/%h/0",
                         k, gin_if.bus_program, gin_if.bus_scan_tag, cfg_done, exp_tag);
            end
            cyc();
        end
        checks++;
        if (gin_if.bus_program !== 1'b0 || cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL prog_exit: program=%b done=%b want 0/1", gin_if.bus_program, cfg_done);
        end
    endtask

    task automatic test_reset();
        rstb = 1'b1;
        cfg_start = 1'b0;
        cfg_tags = '0;
        gin_if.pkt_valid = 1'b0;
        gin_if.pkt_tag = '0;
        gin_if.pkt_data = '0;
        gin_if.bus_ready = '1;
        cyc();
        cyc();
        checks++;
        if ({cfg_done, gin_if.pkt_ready, gin_if.bus_program, gin_if.bus_enable} !== 4'b0000 ||
            gin_if.bus_scan_tag !== '0 || gin_if.bus_tag !== '0 || gin_if.bus_data !== '0 ||
            stall_cycles !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: done=%b rdy=%b prog=%b en=%b scan=%h tag=%h data=%h stall=%h want all 0",
                     cfg_done, gin_if.pkt_ready, gin_if.bus_program, gin_if.bus_enable,
                     gin_if.bus_scan_tag, gin_if.bus_tag, gin_if.bus_data, stall_cycles);
        end
        rstb = 1'b0;
        gin_if.pkt_valid = 1'b1;
        #1;
        checks++;
        if (gin_if.pkt_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_accept: pkt_ready=%b want 0", gin_if.pkt_ready);
        end
        cyc();
        gin_if.pkt_valid = 1'b0;
    endtask

    task automatic test_program();
        logic [TL*N-1:0] tbl;
        for (int i = 0; i < N; i++) tbl[TL*i +: TL] = TL'(i);
        do_program(tbl);
    endtask

    task automatic test_back_to_back();
        gin_if.bus_ready = '1;
        gin_if.pkt_valid = 1'b1;
        gin_if.pkt_tag   = 4'd3;
        gin_if.pkt_data  = 16'hABCD;
        #1;
        checks++;
        if (gin_if.pkt_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready0: got %b want 1", gin_if.pkt_ready);
        end
        cyc();
        gin_if.pkt_tag  = 4'd5;
        gin_if.pkt_data = 16'h1234;
        #1;
        checks++;
        if (gin_if.bus_enable !== 1'b1 || gin_if.bus_tag !== 4'd3 || gin_if.bus_data !== 16'hABCD ||
            gin_if.pkt_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_issue0: en=%b tag=%h data=%h rdy=%b want 1/3/abcd/0",
                     gin_if.bus_enable, gin_if.bus_tag, gin_if.bus_data, gin_if.pkt_ready);
        end
        cyc();
        checks++;
        if (gin_if.bus_enable !== 1'b0 || gin_if.bus_tag !== 4'd3 || gin_if.bus_data !== 16'hABCD ||
            gin_if.pkt_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: en=%b tag=%h data=%h rdy=%b want 0/3/abcd/1",
                     gin_if.bus_enable, gin_if.bus_tag, gin_if.bus_data, gin_if.pkt_ready);
        end
        cyc();
        gin_if.pkt_valid = 1'b0;
        checks++;
        if (gin_if.bus_enable !== 1'b1 || gin_if.bus_tag !== 4'd5 || gin_if.bus_data !== 16'h1234) begin
            errors++;
            $display("FAIL b2b_issue1: en=%b tag=%h data=%h want 1/5/1234",
                     gin_if.bus_enable, gin_if.bus_tag, gin_if.bus_data);
        end
        cyc();
        checks++;
        if (gin_if.bus_enable !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: en=%b want 0", gin_if.bus_enable);
        end
    endtask

    task automatic test_cfg_ignored_when_enable();
        gin_if.pkt_valid = 1'b1;
        gin_if.pkt_tag   = 4'hA;
        gin_if.pkt_data  = 16'h5A5A;
        cyc();
        gin_if.pkt_valid = 1'b0;
        cfg_start = 1'b1;
        #1;
        checks++;
        if (gin_if.bus_enable !== 1'b1 || gin_if.pkt_ready !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ign_setup: en=%b rdy=%b want 1/0", gin_if.bus_enable, gin_if.pkt_ready);
        end
        cyc();
        cfg_start = 1'b0;
        checks++;
        if (gin_if.bus_program !== 1'b0 || cfg_done !== 1'b1 || gin_if.bus_enable !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ignored: prog=%b done=%b en=%b want 0/1/0",
                     gin_if.bus_program, cfg_done, gin_if.bus_enable);
        end
    endtask

    task automatic test_stall();
        logic [TL*N-1:0] tbl;
        for (int i = 0; i < N; i++) tbl[TL*i +: TL] = TL'($urandom);
        do_program(tbl);
        gin_if.pkt_valid = 1'b1;
        gin_if.pkt_tag   = 4'h7;
        gin_if.pkt_data  = 16'hBEEF;
        gin_if.bus_ready = 10'h3FE;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (gin_if.pkt_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got %b want 0", c, gin_if.pkt_ready);
            end
            cyc();
            checks++;
            if (gin_if.bus_enable !== 1'b0) begin
                errors++;
                $display("FAIL stall_enable[%0d]: got %b want 0", c, gin_if.bus_enable);
            end
        end
        checks++;
`ifdef GIN_STALL_CNT_EN
        if (stall_cycles !== 16'd5) begin
            errors++;
            $display("FAIL stall_count: got %0d want 5", stall_cycles);
        end
`else
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL stall_count: got %0d want 0", stall_cycles);
        end
`endif
        gin_if.bus_ready = '1;
        #1;
        checks++;
        if (gin_if.pkt_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: pkt_ready=%b want 1", gin_if.pkt_ready);
        end
        cyc();
        gin_if.pkt_valid = 1'b0;
        checks++;
        if (gin_if.bus_enable !== 1'b1 || gin_if.bus_tag !== 4'h7 || gin_if.bus_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL stall_issue: en=%b tag=%h data=%h want 1/7/beef",
                     gin_if.bus_enable, gin_if.bus_tag, gin_if.bus_data);
        end
        cyc();
    endtask

    task automatic test_cfg_priority();
        logic [TL*N-1:0] tbl;
        for (int i = 0; i < N; i++) tbl[TL*i +: TL] = TL'($urandom);
        gin_if.bus_ready = '1;
        gin_if.pkt_valid = 1'b1;
        gin_if.pkt_tag   = 4'h1;
        gin_if.pkt_data  = 16'hDEAD;
        do_program(tbl);
    endtask

    task automatic test_reset_mid_program();
        logic [TL*N-1:0] tbl;
        for (int i = 0; i < N; i++) tbl[TL*i +: TL] = TL'($urandom);
        cfg_tags  = tbl;
        cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        repeat (4) cyc();
        rstb = 1'b1;
        cyc();
        rstb = 1'b0;
        checks++;
        if (gin_if.bus_program !== 1'b0 || cfg_done !== 1'b0 || gin_if.bus_scan_tag !== '0 ||
            gin_if.bus_enable !== 1'b0 || stall_cycles !== 16'h0) begin
            errors++;
            $display("FAIL midprog_reset: prog=%b done=%b scan=%h en=%b stall=%h want 0",
                     gin_if.bus_program, cfg_done, gin_if.bus_scan_tag, gin_if.bus_enable, stall_cycles);
        end
        gin_if.bus_ready = '1;
        gin_if.pkt_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (gin_if.pkt_ready !== 1'b0 || gin_if.bus_program !== 1'b0) begin
                errors++;
                $display("FAIL after_reset_idle[%0d]: rdy=%b prog=%b want 0/0",
                         c, gin_if.pkt_ready, gin_if.bus_program);
            end
            cyc();
        end
        gin_if.pkt_valid = 1'b0;
        do_program(tbl);
    endtask

    // Scoreboard: accepted packets queue up and must appear on the bus in
    // the following cycle; stall count accumulates every refused offer.
    task automatic test_random();
        logic [TL+BW-1:0] sb[$];
        logic [TL+BW-1:0] pkt;
        logic             last_issue = 1'b0;
        logic             seen = 1'b0;
        logic             exp_rdy, acc;
        logic [TL-1:0]    last_tag = '0;
        logic [BW-1:0]    last_data = '0;
        int               exp_stall = 0;
        logic [TL*N-1:0]  tbl;
        for (int i = 0; i < N; i++) tbl[TL*i +: TL] = TL'($urandom);
        do_program(tbl);
        for (int n = 0; n < 400; n++) begin
            gin_if.pkt_valid = ($urandom_range(0, 9) < 7);
            gin_if.pkt_tag   = TL'($urandom);
            gin_if.pkt_data  = BW'($urandom);
            gin_if.bus_ready = ($urandom_range(0, 3) != 0) ? '1 : N'($urandom);
            #1;
            exp_rdy = (gin_if.bus_ready == {N{1'b1}}) && !last_issue;
            checks++;
            if (gin_if.pkt_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rnd_ready[%0d]: got %b want %b", n, gin_if.pkt_ready, exp_rdy);
            end
            acc = gin_if.pkt_valid && exp_rdy;
            if (acc) sb.push_back({gin_if.pkt_tag, gin_if.pkt_data});
            if (gin_if.pkt_valid && !exp_rdy && exp_stall < 65535) exp_stall++;
            cyc();
            checks++;
            if (acc) begin
                pkt = sb.pop_front();
                last_tag  = pkt[TL+BW-1:BW];
                last_data = pkt[BW-1:0];
                seen = 1'b1;
            end
            if (gin_if.bus_enable !== acc ||
                (seen && (gin_if.bus_tag !== last_tag || gin_if.bus_data !== last_data))) begin
                errors++;
                $display("FAIL rnd_bus[%0d]: en=%b tag=%h data=%h want %b/%h/%h",
                         n, gin_if.bus_enable, gin_if.bus_tag, gin_if.bus_data, acc, last_tag, last_data);
            end
`ifdef GIN_STALL_CNT_EN
            checks++;
            if (stall_cycles !== 16'(exp_stall)) begin
                errors++;
                $display("FAIL rnd_stall[%0d]: got %0d want %0d", n, stall_cycles, exp_stall);
            end
`endif
            last_issue = acc;
        end
        gin_if.pkt_valid = 1'b0;
        gin_if.bus_ready = '1;
        cyc();
    endtask

`ifdef GIN_STALL_CNT_EN
    task automatic test_stall_saturate();
        gin_if.pkt_valid = 1'b1;
        gin_if.bus_ready = '0;
        repeat (70000) cyc();
        checks++;
        if (stall_cycles !== 16'hFFFF) begin
            errors++;
            $display("FAIL stall_saturate: got %h want ffff", stall_cycles);
        end
        gin_if.pkt_valid = 1'b0;
        gin_if.bus_ready = '1;
        cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        checks++;
        if (stall_cycles !== 16'h0 || gin_if.bus_program !== 1'b1) begin
            errors++;
            $display("FAIL stall_clear: stall=%h prog=%b want 0/1", stall_cycles, gin_if.bus_program);
        end
        repeat (N + 1) cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_program();
        test_back_to_back();
        test_cfg_ignored_when_enable();
        test_stall();
        test_cfg_priority();
        test_reset_mid_program();
        test_random();
`ifdef GIN_STALL_CNT_EN
        test_stall_saturate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
